motor_pwm_driver: RTL and testbench

- Consumes the 5-bit MC1/MC2 motor-command words from the direction controller (bits 1:0 direction, bits 4:2 power level) and drives two H-bridge channels: MC1 is the right motor, MC2 the left.
- Produces per-channel IN_A/IN_B direction pins and a PWM enable line.
- Inserts dead time on every forward/reverse reversal.
- Applies command changes only at PWM period boundaries, so no pulse is ever truncated.

---
 rtl/motor_pkg.sv | 50 +++++
 rtl/motor_channel.sv | 124 ++++++++++++
 rtl/motor_pwm_driver.sv | 87 ++++++++
 tb/tb_motor_pwm_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor-command definitions: MC word layout, direction codes, channel
// state encodings and the power-level to PWM-duty table.
package motor_pkg;

    localparam int MC_W       = 5;
    localparam int MC_DIR_LSB = 0;
    localparam int MC_DIR_MSB = 1;
    localparam int MC_PWR_LSB = 2;
    localparam int MC_PWR_MSB = 4;
    localparam int PWR_W      = MC_PWR_MSB - MC_PWR_LSB + 1;

    // 2'b11 is a second neutral code; both neutral codes idle the bridge.
    typedef enum logic [1:0] {
        DIR_FWD     = 2'b00,
        DIR_NEU     = 2'b01,
        DIR_REV     = 2'b10,
        DIR_NEU_ALT = 2'b11
    } dir_e;

    localparam logic [MC_W-1:0] MC_NEUTRAL = 5'b00001;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_FWD  = 2'd1,
        CH_REV  = 2'd2,
        CH_DEAD = 2'd3
    } ch_state_e;

    function automatic dir_e mc_dir(input logic [MC_W-1:0] mc);
        return dir_e'(mc[MC_DIR_MSB:MC_DIR_LSB]);
    endfunction

    function automatic logic [PWR_W-1:0] mc_power(input logic [MC_W-1:0] mc);
        return mc[MC_PWR_MSB:MC_PWR_LSB];
    endfunction

    // High ticks per period; level 1 sits between 1/8 and 2/8 so the bottom
    // of the range is not two equal-looking steps.
    function automatic logic [31:0] duty_ticks(input logic [PWR_W-1:0] level,
                                               input int unsigned      period);
        logic [31:0] eighth;
        eighth = period / 8;
        case (level)
            3'd0:    duty_ticks = eighth;
            3'd1:    duty_ticks = period / 6;
            default: duty_ticks = eighth * 32'(level);
        endcase
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: boundary command latch, IDLE/FWD/REV/DEAD FSM with
// dead-time counter, and registered IN_A/IN_B/PWM pins.
module motor_channel
    import motor_pkg::*;
#(
    parameter int PERIOD      = 240,
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_pwm_cnt,
    input  logic [MC_W-1:0]  i_mc,
    output logic             o_in_a,
    output logic             o_in_b,
    output logic             o_pwm
);

    localparam int DEAD_W = 8;

    ch_state_e         r_state;
    ch_state_e         w_state_next;
    logic [MC_W-1:0]   r_latch;
    logic [MC_W-1:0]   w_latch_next;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic              r_in_a;
    logic              r_in_b;
    logic              r_pwm;
    logic [31:0]       w_duty;
    logic              w_below_duty;
    logic              w_driving;
    dir_e              w_dir_next;

    always_comb begin
        w_latch_next = r_latch;
        if (!i_enable) begin
            w_latch_next = MC_NEUTRAL;
        end else if (i_boundary) begin
            w_latch_next = i_mc;
        end
    end

    // Decisions use the value the latch is about to take, so the state
    // change lands on the same edge as the boundary sample.
    assign w_dir_next = mc_dir(w_latch_next);

    always_comb begin
        w_state_next = r_state;
        if (!i_enable) begin
            w_state_next = CH_IDLE;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (w_dir_next == DIR_FWD) begin
                        w_state_next = CH_FWD;
                    end else if (w_dir_next == DIR_REV) begin
                        w_state_next = CH_REV;
                    end
                end
                CH_FWD: begin
                    if (w_dir_next == DIR_REV) begin
                        w_state_next = CH_DEAD;
                    end else if (w_dir_next != DIR_FWD) begin
                        w_state_next = CH_IDLE;
                    end
                end
                CH_REV: begin
                    if (w_dir_next == DIR_FWD) begin
                        w_state_next = CH_DEAD;
                    end else if (w_dir_next != DIR_REV) begin
                        w_state_next = CH_IDLE;
                    end
                end
                CH_DEAD: begin
                    // Leave on the edge where the counter drops to zero.
                    if (r_dead_cnt == DEAD_W'(1)) begin
                        if (w_dir_next == DIR_FWD) begin
                            w_state_next = CH_FWD;
                        end else if (w_dir_next == DIR_REV) begin
                            w_state_next = CH_REV;
                        end else begin
                            w_state_next = CH_IDLE;
                        end
                    end
                end
                default: w_state_next = CH_IDLE;
            endcase
        end
    end

    assign w_duty       = duty_ticks(mc_power(r_latch), unsigned'(PERIOD));
    assign w_below_duty = (32'(i_pwm_cnt) < w_duty);
    assign w_driving    = (r_state == CH_FWD) || (r_state == CH_REV);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= CH_IDLE;
            r_latch    <= MC_NEUTRAL;
            r_dead_cnt <= '0;
            r_in_a     <= 1'b0;
            r_in_b     <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_latch <= w_latch_next;
            if (w_state_next == CH_DEAD && r_state != CH_DEAD) begin
                r_dead_cnt <= DEAD_W'(DEAD_CYCLES);
            end else if (r_state == CH_DEAD) begin
                r_dead_cnt <= r_dead_cnt - DEAD_W'(1);
            end
            // Both legs derive from one state value, so they are exclusive.
            r_in_a <= i_enable && (r_state == CH_FWD);
            r_in_b <= i_enable && (r_state == CH_REV);
            r_pwm  <= i_enable && w_driving && w_below_duty;
        end
    end

    assign o_in_a = r_in_a;
    assign o_in_b = r_in_b;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared prescaler / period counter and one
// motor_channel per motor (index 0 = right/MC1, index 1 = left/MC2).
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int PERIOD      = 240,
    parameter int DEAD_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic [MC_W-1:0] i_mc1,
    input  logic [MC_W-1:0] i_mc2,
    output logic            o_r_in_a,
    output logic            o_r_in_b,
    output logic            o_r_pwm,
    output logic            o_l_in_a,
    output logic            o_l_in_b,
    output logic            o_l_pwm,
    output logic            o_period_start
);

    localparam int CNT_W   = $clog2(PERIOD);
    localparam int PRESC_W = 16;
    localparam int N_CH    = 2;

    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_pwm_cnt;
    logic               r_period_start;
    logic               w_tick;
    logic               w_boundary;
    logic [MC_W-1:0]    w_mc [N_CH];
    logic [N_CH-1:0]    w_in_a;
    logic [N_CH-1:0]    w_in_b;
    logic [N_CH-1:0]    w_pwm;

    assign w_tick     = (r_presc == PRESC_W'(CLK_DIV - 1));
    assign w_boundary = w_tick && (r_pwm_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc        <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + CNT_W'(1);
            end
            // High only on the first CLK of count 0, even when CLK_DIV > 1.
            r_period_start <= w_boundary;
        end
    end

    assign w_mc[0] = i_mc1;
    assign w_mc[1] = i_mc2;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            motor_channel #(
                .PERIOD      (PERIOD),
                .DEAD_CYCLES (DEAD_CYCLES),
                .CNT_W       (CNT_W)
            ) u_channel (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_enable   (i_enable),
                .i_boundary (w_boundary),
                .i_pwm_cnt  (r_pwm_cnt),
                .i_mc       (w_mc[gi]),
                .o_in_a     (w_in_a[gi]),
                .o_in_b     (w_in_b[gi]),
                .o_pwm      (w_pwm[gi])
            );
        end
    endgenerate

    assign o_r_in_a       = w_in_a[0];
    assign o_r_in_b       = w_in_b[0];
    assign o_r_pwm        = w_pwm[0];
    assign o_l_in_a       = w_in_a[1];
    assign o_l_in_b       = w_in_b[1];
    assign o_l_pwm        = w_pwm[1];
    assign o_period_start = r_period_start;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Period-level scoreboard bench for motor_pwm_driver (CLK_DIV=1, PERIOD=240,
// DEAD_CYCLES=16): expected per-period pin statistics are queued, then compared.
module tb_motor_pwm_driver;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] mc1    = 5'b00001;
    logic [4:0] mc2    = 5'b00001;
    logic       r_a, r_b, r_p, l_a, l_b, l_p, ps;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_overlap = 0;

    int hi_tbl [8] = '{30, 40, 60, 90, 120, 150, 180, 210};

    typedef struct {
        string tag;
        int    hi_r;
        int    zero_r;
        int    a;
        int    b;
        int    hi_l;
        int    la;
        int    lb;
        int    ps;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .CLK_DIV     (1),
        .PERIOD      (240),
        .DEAD_CYCLES (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_mc1          (mc1),
        .i_mc2          (mc2),
        .o_r_in_a       (r_a),
        .o_r_in_b       (r_b),
        .o_r_pwm        (r_p),
        .o_l_in_a       (l_a),
        .o_l_in_b       (l_b),
        .o_l_pwm        (l_p),
        .o_period_start (ps)
    );

    always @(negedge clk) begin
        if ((r_a && r_b) || (l_a && l_b)) n_overlap++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int hi_r, input int zero_r,
                            input int a, input int b, input int hi_l,
                            input int la, input int lb);
        exp_t e;
        e.tag = tag; e.hi_r = hi_r; e.zero_r = zero_r; e.a = a; e.b = b;
        e.hi_l = hi_l; e.la = la; e.lb = lb; e.ps = 1;
        sb.push_back(e);
    endtask

    // Starts on the negedge where PERIOD_START is seen; ends on the next one.
    task automatic measure(input int at, input logic [4:0] m1,
                           input logic [4:0] m2, input logic en);
        int   hi_r = 0, zero_r = 0, hi_l = 0, psc = 0;
        int   a = 0, b = 0, la = 0, lb = 0;
        exp_t e;
        for (int i = 0; i < 240; i++) begin
            hi_r += int'(r_p);
            hi_l += int'(l_p);
            psc  += int'(ps);
            if (!r_a && !r_b && !r_p) zero_r++;
            if (i == 239) begin
                a = int'(r_a); b = int'(r_b); la = int'(l_a); lb = int'(l_b);
            end
            if (i == at) begin
                mc1 = m1; mc2 = m2; enable = en;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check_eq({e.tag, ".r_high"}, hi_r, e.hi_r);
        check_eq({e.tag, ".r_allzero"}, zero_r, e.zero_r);
        check_eq({e.tag, ".r_in_a"}, a, e.a);
        check_eq({e.tag, ".r_in_b"}, b, e.b);
        check_eq({e.tag, ".l_high"}, hi_l, e.hi_l);
        check_eq({e.tag, ".l_in_a"}, la, e.la);
        check_eq({e.tag, ".l_in_b"}, lb, e.lb);
        check_eq({e.tag, ".period_starts"}, psc, e.ps);
        $display("[TB] %s: r_high=%0d r_allzero=%0d r_a=%0d r_b=%0d l_high=%0d l_a=%0d l_b=%0d ps=%0d",
                 e.tag, hi_r, zero_r, a, b, hi_l, la, lb, psc);
    endtask

    task automatic wait_ps(output int cycles, output int nonzero);
        cycles  = 0;
        nonzero = 0;
        while (ps !== 1'b1 && cycles < 400) begin
            if (r_a || r_b || r_p || l_a || l_b || l_p) nonzero++;
            cycles++;
            @(negedge clk);
        end
        if (ps !== 1'b1) check_eq("period_start_timeout", 0, 1);
    endtask

    initial begin
        int         cyc, nz, prev;
        logic [4:0] m;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs", int'({r_a, r_b, r_p, l_a, l_b, l_p, ps}), 0);

        rst_n  = 1'b1;
        mc1    = 5'b10000;
        enable = 1'b1;
        wait_ps(cyc, nz);
        check_eq("first_boundary_cycles", cyc, 240);
        check_eq("idle_before_first_latch", nz, 0);

        push_exp("fwd4_first", 120, 1, 1, 0, 0, 0, 0);
        measure(-1, mc1, mc2, enable);
        push_exp("fwd4_steady", 120, 0, 1, 0, 0, 0, 0);
        measure(-1, mc1, mc2, enable);

        prev = 120;
        for (int n = 0; n < 8; n++) begin
            m = 5'(n << 2);
            push_exp($sformatf("sweep%0d_old", n), prev, 0, 1, 0, 0, 0, 0);
            measure(0, m, mc2, 1'b1);
            push_exp($sformatf("sweep%0d_new", n), hi_tbl[n], 0, 1, 0, 0, 0, 0);
            measure(-1, mc1, mc2, enable);
            prev = hi_tbl[n];
        end

        push_exp("rev_req_midperiod", 210, 0, 1, 0, 0, 0, 0);
        measure(100, 5'b11110, mc2, 1'b1);
        push_exp("rev_after_dead", 194, 16, 0, 1, 0, 0, 0);
        measure(-1, mc1, mc2, enable);
        push_exp("rev_steady", 210, 0, 0, 1, 0, 0, 0);
        measure(100, 5'b11100, mc2, 1'b1);
        push_exp("fwd_dead_neutral_req", 194, 16, 1, 0, 0, 0, 0);
        measure(5, 5'b00001, mc2, 1'b1);
        push_exp("fwd_to_idle", 0, 239, 0, 0, 0, 0, 0);
        measure(100, 5'b01000, mc2, 1'b1);
        push_exp("idle_to_fwd2_no_dead", 60, 1, 1, 0, 0, 0, 0);
        measure(-1, mc1, mc2, enable);

        push_exp("enable_drop", 30, 209, 0, 0, 0, 0, 0);
        measure(30, mc1, mc2, 1'b0);
        push_exp("enable_restored_wait", 0, 240, 0, 0, 0, 0, 0);
        measure(100, mc1, mc2, 1'b1);
        push_exp("enable_resume", 60, 1, 1, 0, 0, 0, 0);
        measure(100, mc1, 5'b01110, 1'b1);
        push_exp("left_rev3", 60, 0, 1, 0, 90, 0, 1);
        measure(100, 5'b11110, mc2, 1'b1);

        repeat (8) @(negedge clk);
        check_eq("dead_right_pins", int'({r_a, r_b, r_p}), 0);
        check_eq("left_driving_pre_reset", int'(l_b), 1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_outputs", int'({r_a, r_b, r_p, l_a, l_b, l_p, ps}), 0);
        repeat (3) @(negedge clk);
        check_eq("reset_held_outputs", int'({r_a, r_b, r_p, l_a, l_b, l_p, ps}), 0);
        rst_n = 1'b1;
        wait_ps(cyc, nz);
        check_eq("post_reset_boundary_cycles", cyc, 240);
        check_eq("post_reset_idle", nz, 0);
        push_exp("post_reset_rev", 210, 1, 0, 1, 90, 0, 1);
        measure(-1, mc1, mc2, enable);

        check_eq("in_a_in_b_overlap", n_overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
